// File: rtl/relu_maxpool_stream.sv
// Streaming ReLU followed by a KxK / stride-S max-pool over a row-major, channel-innermost frame.
// Partial window maxima live in a small array indexed by (output column, channel, row-window slot).
`timescale 1ns/1ps
module relu_maxpool_stream #(
  parameter int DATA_W = 16,
  parameter int IN_W   = 55,
  parameter int IN_H   = 55,
  parameter int CH     = 96,
  parameter int POOL   = 3,
  parameter int STRIDE = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              relu_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_done,
  output logic              busy
);

  localparam int OUT_W = (IN_W - POOL) / STRIDE + 1;
  localparam int OUT_H = (IN_H - POOL) / STRIDE + 1;
  localparam int NW    = (POOL + STRIDE - 1) / STRIDE;
  localparam int DEPTH = OUT_W * CH * NW;
  localparam int EW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
  localparam int XW    = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int YW    = (IN_H > 1) ? $clog2(IN_H) : 1;

  logic [CW-1:0] ch_cnt;
  logic [XW-1:0] col_cnt;
  logic [YW-1:0] row_cnt;
  logic          relu_hold;
  logic          relu_eff;
  logic          accept;
  logic          first_beat;
  logic          last_ch;
  logic          last_col;
  logic          last_row;
  logic          frame_last;
  logic signed [DATA_W-1:0] v;

  int   oy_c   [NW];
  int   ox_c   [NW];
  int   slot_c [NW];
  logic y_ok    [NW];
  logic x_ok    [NW];
  logic y_first [NW];
  logic x_first [NW];
  logic y_end   [NW];
  logic x_end   [NW];
  logic [EW-1:0]            idx [NW][NW];
  logic signed [DATA_W-1:0] upd [NW][NW];
  logic signed [DATA_W-1:0] mem [DEPTH];

  logic                     done;
  logic                     done_last;
  logic signed [DATA_W-1:0] done_val;

  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign first_beat = (ch_cnt == '0) && (col_cnt == '0) && (row_cnt == '0);
  assign last_ch    = (ch_cnt == CW'(CH - 1));
  assign last_col   = (col_cnt == XW'(IN_W - 1));
  assign last_row   = (row_cnt == YW'(IN_H - 1));
  assign frame_last = last_ch && last_col && last_row;
  assign relu_eff   = first_beat ? relu_en : relu_hold;
  assign v          = (relu_eff && in_data[DATA_W-1]) ? '0 : $signed(in_data);

  // Candidate windows along each axis: the one starting at or before this index, and up to NW-1 earlier ones.
  always_comb begin
    for (int i = 0; i < NW; i++) begin
      oy_c[i]    = int'(row_cnt) / STRIDE - i;
      y_ok[i]    = (oy_c[i] >= 0) && (oy_c[i] < OUT_H) && (int'(row_cnt) - oy_c[i] * STRIDE < POOL);
      y_first[i] = (int'(row_cnt) == oy_c[i] * STRIDE);
      y_end[i]   = (int'(row_cnt) == oy_c[i] * STRIDE + POOL - 1);
      slot_c[i]  = (oy_c[i] >= 0) ? oy_c[i] % NW : 0;
      ox_c[i]    = int'(col_cnt) / STRIDE - i;
      x_ok[i]    = (ox_c[i] >= 0) && (ox_c[i] < OUT_W) && (int'(col_cnt) - ox_c[i] * STRIDE < POOL);
      x_first[i] = (int'(col_cnt) == ox_c[i] * STRIDE);
      x_end[i]   = (int'(col_cnt) == ox_c[i] * STRIDE + POOL - 1);
    end
  end

  always_comb begin
    for (int i = 0; i < NW; i++) begin
      for (int j = 0; j < NW; j++) begin
        idx[i][j] = EW'((ox_c[j] * CH + int'(ch_cnt)) * NW + slot_c[i]);
        upd[i][j] = ((y_first[i] && x_first[j]) || (v > mem[idx[i][j]])) ? v : mem[idx[i][j]];
      end
    end
  end

  // At most one window can finish on a given element: its bottom-right corner.
  always_comb begin
    done      = 1'b0;
    done_last = 1'b0;
    done_val  = '0;
    for (int i = 0; i < NW; i++) begin
      for (int j = 0; j < NW; j++) begin
        if (y_ok[i] && x_ok[j] && y_end[i] && x_end[j]) begin
          done      = 1'b1;
          done_val  = upd[i][j];
          done_last = (oy_c[i] == OUT_H - 1) && (ox_c[j] == OUT_W - 1) && last_ch;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < NW; i++) begin
        for (int j = 0; j < NW; j++) begin
          if (y_ok[i] && x_ok[j]) mem[idx[i][j]] <= upd[i][j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_cnt     <= '0;
      col_cnt    <= '0;
      row_cnt    <= '0;
      relu_hold  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_done <= accept && frame_last;
      if (accept) begin
        busy <= !frame_last;
        if (first_beat) relu_hold <= relu_en;
        if (last_ch) begin
          ch_cnt <= '0;
          if (last_col) begin
            col_cnt <= '0;
            if (last_row) row_cnt <= '0;
            else          row_cnt <= row_cnt + 1'b1;
          end else begin
            col_cnt <= col_cnt + 1'b1;
          end
        end else begin
          ch_cnt <= ch_cnt + 1'b1;
        end
      end
      // A completing window is only accepted when the register is free or draining this cycle.
      if (accept && done) begin
        out_valid <= 1'b1;
        out_data  <= done_val;
        out_last  <= done_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Bench for relu_maxpool_stream: a 5x5x2 instance and a 6x5x2 instance (3x3 pool, stride 2) share the stimulus.
`timescale 1ns/1ps
module tb_relu_maxpool_stream;
  localparam int DW = 16;
  localparam int H = 5;
  localparam int CHN = 2;
  localparam int K = 3;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic relu_en = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;

  logic rdy5, ov5, ol5, fd5, bz5;
  logic rdy6, ov6, ol6, fd6, bz6;
  logic [DW-1:0] od5, od6;
  logic sel = 1'b0;
  logic rdy_m, ov_m, ol_m, fd_m, bz_m;
  logic [DW-1:0] od_m;

  always #5 clk = ~clk;

  relu_maxpool_stream #(.DATA_W(DW), .IN_W(5), .IN_H(H), .CH(CHN), .POOL(K), .STRIDE(S)) dut5 (
    .clk(clk), .rst_n(rst_n), .relu_en(relu_en), .in_valid(in_valid), .in_ready(rdy5),
    .in_data(in_data), .out_valid(ov5), .out_ready(out_ready), .out_data(od5),
    .out_last(ol5), .frame_done(fd5), .busy(bz5));

  relu_maxpool_stream #(.DATA_W(DW), .IN_W(6), .IN_H(H), .CH(CHN), .POOL(K), .STRIDE(S)) dut6 (
    .clk(clk), .rst_n(rst_n), .relu_en(relu_en), .in_valid(in_valid), .in_ready(rdy6),
    .in_data(in_data), .out_valid(ov6), .out_ready(out_ready), .out_data(od6),
    .out_last(ol6), .frame_done(fd6), .busy(bz6));

  assign rdy_m = sel ? rdy6 : rdy5;
  assign ov_m  = sel ? ov6  : ov5;
  assign ol_m  = sel ? ol6  : ol5;
  assign fd_m  = sel ? fd6  : fd5;
  assign bz_m  = sel ? bz6  : bz5;
  assign od_m  = sel ? od6  : od5;

  typedef struct packed {
    logic [1:0]        kind;
    logic              relu;
    logic [3:0]        in_w;
    logic [7:0][15:0]  exp;
  } vec_t;

  vec_t tbl [5];
  int   vectors = 0;
  int   miscompares = 0;
  int   stim [$];
  int   exp_d [$];
  bit   exp_l [$];
  int   got_d [$];
  bit   got_l [$];
  int   fd_cnt = 0;
  int   cycles;

  always @(negedge clk) begin
    if (rst_n) begin
      if (ov_m && out_ready) begin
        got_d.push_back(int'($signed(od_m)));
        got_l.push_back(ol_m);
      end
      if (fd_m) fd_cnt++;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input int kind, input int relu, input int w,
                              input int e0, input int e1, input int e2, input int e3,
                              input int e4, input int e5, input int e6, input int e7);
    vec_t r;
    r.kind = 2'(kind);
    r.relu = 1'(relu);
    r.in_w = 4'(w);
    r.exp[0] = 16'(e0); r.exp[1] = 16'(e1); r.exp[2] = 16'(e2); r.exp[3] = 16'(e3);
    r.exp[4] = 16'(e4); r.exp[5] = 16'(e5); r.exp[6] = 16'(e6); r.exp[7] = 16'(e7);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", int'(rdy_m), 1);
    chk("rst_out_valid", int'(ov_m), 0);
    chk("rst_out_data", int'(od_m), 0);
    chk("rst_out_last", int'(ol_m), 0);
    chk("rst_frame_done", int'(fd_m), 0);
    chk("rst_busy", int'(bz_m), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    got_d.delete(); got_l.delete();
    fd_cnt = 0;
  endtask

  task automatic build_stim(input int kind, input int w, input int nfr);
    stim.delete();
    for (int f = 0; f < nfr; f++)
      for (int i = 0; i < H * w * CHN; i++)
        case (kind)
          0: stim.push_back(i);
          1: stim.push_back(-100 - i);
          2: stim.push_back((i == (2 * w + 2) * CHN) ? 1000 : 0);
          default: stim.push_back(int'($urandom_range(0, 65535)) - 32768);
        endcase
  endtask

  // Direct window maxima over the first frame in stim.
  task automatic model(input bit relu, input int w);
    int ow, oh, m, x, vv;
    ow = (w - K) / S + 1;
    oh = (H - K) / S + 1;
    exp_d.delete(); exp_l.delete();
    for (int oy = 0; oy < oh; oy++)
      for (int ox = 0; ox < ow; ox++)
        for (int c = 0; c < CHN; c++) begin
          m = 0;
          for (int dy = 0; dy < K; dy++)
            for (int dx = 0; dx < K; dx++) begin
              x = stim[((oy * S + dy) * w + ox * S + dx) * CHN + c];
              vv = (relu && x < 0) ? 0 : x;
              if ((dy == 0 && dx == 0) || vv > m) m = vv;
            end
          exp_d.push_back(m);
          exp_l.push_back(oy == oh - 1 && ox == ow - 1 && c == CHN - 1);
        end
  endtask

  task automatic run_frames(input int n, input bit relu_base, input int stall, input int hold_exp,
                            input bit rnd, input bit check_end, output int ncyc);
    int k, scnt;
    bit stalled, acc;
    k = 0; scnt = 0; stalled = 0; ncyc = 0;
    in_valid = 1'b1;
    in_data = DW'(stim[0]);
    relu_en = relu_base;
    while (k < n && ncyc < 8 * n + 200) begin
      @(negedge clk);
      if (scnt > 0) begin
        chk("stall_in_ready", int'(rdy_m), 0);
        chk("stall_out_data", int'($signed(od_m)), hold_exp);
      end
      if (k == n / 2 - 1) chk("busy_mid", int'(bz_m), 1);
      acc = in_valid && rdy_m;
      @(posedge clk);
      ncyc++;
      if (acc) k++;
      #1;
      if (stall > 0 && !stalled && ov_m) begin
        out_ready = 1'b0; stalled = 1'b1; scnt = stall;
      end else if (scnt > 0) begin
        scnt--;
        if (scnt == 0) out_ready = 1'b1;
      end else if (rnd) begin
        out_ready = 1'($urandom_range(0, 1));
      end
      if (k < n) begin
        in_data = DW'(stim[k]);
        relu_en = (rnd && k > 0) ? 1'($urandom_range(0, 1)) : relu_base;
      end else begin
        in_valid = 1'b0;
      end
    end
    if (k < n) chk("frame_timeout_beats", k, n);
    if (check_end) begin
      @(negedge clk);
      chk("frame_done_pulse", int'(fd_m), 1);
      chk("busy_clear", int'(bz_m), 0);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare_out(input string tag);
    chk({tag, "_count"}, got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size(); i++) begin
      if (i < got_d.size()) begin
        chk({tag, "_data"}, got_d[i], exp_d[i]);
        chk({tag, "_last"}, int'(got_l[i]), int'(exp_l[i]));
      end
    end
    got_d.delete(); got_l.delete();
  endtask

  task automatic table_expect(input int t, input int nfr);
    exp_d.delete(); exp_l.delete();
    for (int f = 0; f < nfr; f++)
      for (int j = 0; j < 8; j++) begin
        exp_d.push_back(int'($signed(tbl[t].exp[j])));
        exp_l.push_back(j == 7);
      end
  endtask

  initial begin
    int nfr;
    int w;
    tbl[0] = mk(0, 1, 5, 24, 25, 28, 29, 44, 45, 48, 49);
    tbl[1] = mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2] = mk(1, 0, 5, -100, -101, -104, -105, -120, -121, -124, -125);
    tbl[3] = mk(2, 1, 5, 1000, 0, 1000, 0, 1000, 0, 1000, 0);
    tbl[4] = mk(0, 1, 6, 28, 29, 32, 33, 52, 53, 56, 57);

    repeat (2) @(posedge clk);
    for (int t = 0; t < 5; t++) begin
      w = int'(tbl[t].in_w);
      sel = (w == 6);
      nfr = (w == 6) ? 2 : 1;
      do_reset();
      build_stim(int'(tbl[t].kind), w, nfr);
      table_expect(t, nfr);
      run_frames(stim.size(), tbl[t].relu, 0, 0, 1'b0, 1'b1, cycles);
      drain();
      compare_out($sformatf("vec%0d", t));
      chk($sformatf("vec%0d_cycles", t), cycles, stim.size());
      chk($sformatf("vec%0d_frames", t), fd_cnt, nfr);
    end

    // Backpressure held for 10 cycles at the first output.
    sel = 1'b0;
    do_reset();
    build_stim(0, 5, 1);
    table_expect(0, 1);
    run_frames(stim.size(), 1'b1, 10, 24, 1'b0, 1'b1, cycles);
    drain();
    compare_out("stall");

    // Reset in the middle of a frame, then a clean frame.
    do_reset();
    build_stim(0, 5, 1);
    run_frames(20, 1'b1, 0, 0, 1'b0, 1'b0, cycles);
    do_reset();
    table_expect(0, 1);
    run_frames(stim.size(), 1'b1, 0, 0, 1'b0, 1'b1, cycles);
    drain();
    compare_out("midreset");

    // Random data, random relu mode, random downstream readiness.
    for (int r = 0; r < 4; r++) begin
      bit rl;
      rl = 1'($urandom_range(0, 1));
      build_stim(3, 5, 1);
      model(rl, 5);
      fd_cnt = 0;
      run_frames(stim.size(), rl, 0, 0, 1'b1, 1'b0, cycles);
      drain();
      compare_out($sformatf("rand%0d", r));
      chk($sformatf("rand%0d_frames", r), fd_cnt, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
